// File: rtl/spi_tx_sched.sv
// spi_tx_sched: two-requester round-robin writer into an external FIFO, and a
// read sequencer that pulls one word at a time from that FIFO and hands it to
// an SPI shifter with a one-cycle start pulse, waiting for the done pulse.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   en_i                         allows new SPI transfers to begin
//   reqN_valid_i/data_i/ready_o  requester handshakes (N = 0, 1)
//   fifo_data_o, fifo_push_o     FIFO write side
//   fifo_full_i, fifo_empty_i    FIFO status
//   fifo_data_i, fifo_pull_o     FIFO head word and read strobe
//   spi_data_o, spi_start_o      word and start pulse for the shifter
//   spi_done_i                   shifter completion pulse
//   busy_o                       a transfer is in progress
//   level_o                      words currently held in the FIFO
//   tx_cnt_o                     completed transfers, wrapping at 16 bits
module spi_tx_sched #(
    parameter int unsigned g_width = 32,
    parameter int unsigned g_depth = 4,
    localparam int unsigned c_lvl_w = $clog2(g_depth) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               req0_valid_i,
    input  logic [g_width-1:0] req0_data_i,
    output logic               req0_ready_o,
    input  logic               req1_valid_i,
    input  logic [g_width-1:0] req1_data_i,
    output logic               req1_ready_o,
    output logic [g_width-1:0] fifo_data_o,
    output logic               fifo_push_o,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i,
    input  logic [g_width-1:0] fifo_data_i,
    output logic               fifo_pull_o,
    output logic [g_width-1:0] spi_data_o,
    output logic               spi_start_o,
    input  logic               spi_done_i,
    output logic               busy_o,
    output logic [c_lvl_w-1:0] level_o,
    output logic [15:0]        tx_cnt_o
);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_t;

    localparam logic [c_lvl_w-1:0] c_level_max = c_lvl_w'(g_depth);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;
    logic [c_lvl_w-1:0] r_level;
    logic [15:0]        r_tx_cnt;
    logic [g_width-1:0] r_spi_data;

    logic w_grant_vld;
    logic w_grant_idx;
    logic w_push;
    logic w_pull;
    logic w_start;
    logic w_done;

    // Write arbitration: preferred requester first, otherwise the other one.
    always_comb begin
        w_grant_vld = req0_valid_i | req1_valid_i;
        if (r_prio) begin
            w_grant_idx = req1_valid_i ? 1'b1 : 1'b0;
        end else begin
            w_grant_idx = req0_valid_i ? 1'b0 : 1'b1;
        end
        // Gated by rst_i so no strobe escapes while reset is asserted.
        w_push = w_grant_vld & ~fifo_full_i & ~rst_i;
    end

    assign fifo_push_o  = w_push;
    assign fifo_data_o  = !w_grant_vld ? '0 : (w_grant_idx ? req1_data_i : req0_data_i);
    assign req0_ready_o = w_push & ~w_grant_idx;
    assign req1_ready_o = w_push & w_grant_idx;

    // Read sequencer next state and strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pull      = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (en_i && !fifo_empty_i && !rst_i) begin
                    w_pull      = 1'b1;
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                w_start     = 1'b1;
                w_state_nxt = StWait;
            end
            StWait: begin
                if (spi_done_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_prio     <= 1'b0;
            r_level    <= '0;
            r_tx_cnt   <= '0;
            r_spi_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Prefer whoever was not served this cycle.
            if (w_push) begin
                r_prio <= ~w_grant_idx;
            end
            if (w_pull) begin
                r_spi_data <= fifo_data_i;
            end
            if (w_done) begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
            // Push and pull together leave the level unchanged.
            if (w_push && !w_pull && (r_level != c_level_max)) begin
                r_level <= r_level + 1'b1;
            end else if (w_pull && !w_push && (r_level != '0)) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign fifo_pull_o = w_pull;
    assign spi_start_o = w_start;
    assign spi_data_o  = r_spi_data;
    assign busy_o      = (r_state != StIdle);
    assign level_o     = r_level;
    assign tx_cnt_o    = r_tx_cnt;

endmodule
